// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared types, constants and helper functions for the calendar date counter.
//   bcd_t        : one BCD byte (two nibbles, tens:units)
//   MON_JAN..DEC : BCD month codes
//   BCD_MAX_YEAR : last year of the century (99)
//   bcd_inc()    : BCD increment of a byte; 99 wraps to 00
//   is_leap()    : leap-year test on a two-digit BCD year (00 is leap)
// -----------------------------------------------------------------------------
package clock_pkg;

  typedef logic [7:0] bcd_t;

  localparam bcd_t MON_JAN = 8'h01;
  localparam bcd_t MON_FEB = 8'h02;
  localparam bcd_t MON_MAR = 8'h03;
  localparam bcd_t MON_APR = 8'h04;
  localparam bcd_t MON_MAY = 8'h05;
  localparam bcd_t MON_JUN = 8'h06;
  localparam bcd_t MON_JUL = 8'h07;
  localparam bcd_t MON_AUG = 8'h08;
  localparam bcd_t MON_SEP = 8'h09;
  localparam bcd_t MON_OCT = 8'h10;
  localparam bcd_t MON_NOV = 8'h11;
  localparam bcd_t MON_DEC = 8'h12;

  localparam bcd_t BCD_MAX_YEAR = 8'h99;

  // Units digit 9 carries into the tens digit; 99 wraps back to 00 so the
  // year field never produces a non-BCD tens nibble.
  function automatic bcd_t bcd_inc(input bcd_t v);
    bcd_t r;
    if (v == BCD_MAX_YEAR) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Divisible-by-4 test done on the binary value tens*10+units.
  // Year 00 (2000) is leap.
  function automatic logic is_leap(input bcd_t y);
    logic [6:0] b;
    b = 7'(y[7:4]) * 7'd10 + 7'(y[3:0]);
    return (b[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/calendar_date_if.sv
// -----------------------------------------------------------------------------
// calendar_date_if
// Bundles the date counter's pulse inputs and date outputs.
//   end_of_day   : rollover pulse from the time-of-day counter
//   inc_day      : manual set pulse, day +1 (wraps within the month)
//   inc_month    : manual set pulse, month +1 (wraps 12 -> 01)
//   inc_year     : manual set pulse, year +1 (wraps 99 -> 00)
//   day/month/year          : BCD date
//   end_of_month/end_of_year: one-cycle rollover pulses
// master: the pulse source / date consumer; slave: the date counter.
// -----------------------------------------------------------------------------
interface calendar_date_if import clock_pkg::*; ();

  logic end_of_day;
  logic inc_day;
  logic inc_month;
  logic inc_year;
  bcd_t day;
  bcd_t month;
  bcd_t year;
  logic end_of_month;
  logic end_of_year;

  modport master (
    output end_of_day, inc_day, inc_month, inc_year,
    input  day, month, year, end_of_month, end_of_year
  );

  modport slave (
    input  end_of_day, inc_day, inc_month, inc_year,
    output day, month, year, end_of_month, end_of_year
  );

endinterface

// File: rtl/calendar_days_in_month.sv
// -----------------------------------------------------------------------------
// calendar_days_in_month
// Combinational lookup of the last day of a month.
//   month   (in)  : BCD month 01..12
//   year    (in)  : BCD year 00..99, only used for February
//   max_day (out) : BCD 28/29/30/31
// -----------------------------------------------------------------------------
module calendar_days_in_month import clock_pkg::*; (
  input  bcd_t month,
  input  bcd_t year,
  output bcd_t max_day
);

  always_comb begin
    max_day = 8'h31;
    case (month)
      MON_FEB: max_day = is_leap(year) ? 8'h29 : 8'h28;
      MON_APR,
      MON_JUN,
      MON_SEP,
      MON_NOV: max_day = 8'h30;
      default: max_day = 8'h31;
    endcase
  end

endmodule

// File: rtl/calendar_date.sv
// -----------------------------------------------------------------------------
// calendar_date
// BCD day/month/year counter advanced by the time-of-day end_of_day pulse and
// by manual set pulses.
//   clk_100MHz (in) : system clock, rising edge
//   reset_n    (in) : asynchronous active-low reset, loads INIT_* date
//   cal        (slave modport of calendar_date_if) : pulses in, date out
// Priority when pulses coincide: end_of_day > inc_year > inc_month > inc_day;
// only the winner acts.
// -----------------------------------------------------------------------------
module calendar_date import clock_pkg::*; #(
  parameter bcd_t INIT_DAY   = 8'h01,
  parameter bcd_t INIT_MONTH = 8'h01,
  parameter bcd_t INIT_YEAR  = 8'h24
) (
  input logic            clk_100MHz,
  input logic            reset_n,
  calendar_date_if.slave cal
);

  bcd_t r_day;
  bcd_t r_month;
  bcd_t r_year;
  logic r_end_of_month;
  logic r_end_of_year;

  // One-hot action select after priority resolution.
  logic w_do_eod;
  logic w_do_year;
  logic w_do_month;
  logic w_do_day;

  bcd_t w_day_inc;
  bcd_t w_month_inc;
  bcd_t w_year_inc;

  bcd_t w_dim_month;
  bcd_t w_dim_year;
  bcd_t w_max_day;
  bcd_t w_clamped_day;

  assign w_do_eod   = cal.end_of_day;
  assign w_do_year  = !cal.end_of_day && cal.inc_year;
  assign w_do_month = !cal.end_of_day && !cal.inc_year && cal.inc_month;
  assign w_do_day   = !cal.end_of_day && !cal.inc_year && !cal.inc_month
                      && cal.inc_day;

  assign w_day_inc   = bcd_inc(r_day);
  assign w_month_inc = (r_month == MON_DEC) ? MON_JAN : bcd_inc(r_month);
  assign w_year_inc  = bcd_inc(r_year);

  // A single month-length lookup serves every path: the set pulses need the
  // length of the month they move into (for the clamp), while end_of_day and
  // inc_day need the current month's length. Only one action fires per cycle,
  // so the lookup inputs are simply steered by the winning action.
  assign w_dim_month = w_do_month ? w_month_inc : r_month;
  assign w_dim_year  = w_do_year  ? w_year_inc  : r_year;

  calendar_days_in_month u_days_in_month (
    .month   (w_dim_month),
    .year    (w_dim_year),
    .max_day (w_max_day)
  );

  // Valid BCD compares correctly as plain unsigned binary.
  assign w_clamped_day = (r_day > w_max_day) ? w_max_day : r_day;

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_day          <= INIT_DAY;
      r_month        <= INIT_MONTH;
      r_year         <= INIT_YEAR;
      r_end_of_month <= 1'b0;
      r_end_of_year  <= 1'b0;
    end else begin
      r_end_of_month <= 1'b0;
      r_end_of_year  <= 1'b0;
      if (w_do_eod) begin
        if (r_day != w_max_day) begin
          r_day <= w_day_inc;
        end else begin
          r_day          <= 8'h01;
          r_month        <= w_month_inc;
          r_end_of_month <= 1'b1;
          if (r_month == MON_DEC) begin
            r_year        <= w_year_inc;
            r_end_of_year <= 1'b1;
          end
        end
      end else if (w_do_year) begin
        r_year <= w_year_inc;
        r_day  <= w_clamped_day;
      end else if (w_do_month) begin
        r_month <= w_month_inc;
        r_day   <= w_clamped_day;
      end else if (w_do_day) begin
        r_day <= (r_day == w_max_day) ? 8'h01 : w_day_inc;
      end
    end
  end

  assign cal.day          = r_day;
  assign cal.month        = r_month;
  assign cal.year         = r_year;
  assign cal.end_of_month = r_end_of_month;
  assign cal.end_of_year  = r_end_of_year;

endmodule
